// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results and commits in order,
// keeping the register-status table in step through a single registered write port.
module reorder_buffer #(
    parameter int         DEPTH       = 16,
    parameter int         DATA_W      = 32,
    parameter logic [5:0] INVALID_TAG = 6'b010000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    output logic              issue_ready,
    output logic [5:0]        issue_tag,
    input  logic              cdb_valid,
    input  logic [5:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              stat_we,
    output logic [4:0]        stat_index,
    output logic [5:0]        stat_data,
    output logic [4:0]        stat_rd_idx,
    input  logic [5:0]        stat_rd_q,
    output logic              rf_we,
    output logic [4:0]        rf_index,
    output logic [DATA_W-1:0] rf_data,
    output logic [4:0]        count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DEPTH-1:0]             ready_q, ready_d;
    logic [DEPTH-1:0][4:0]        dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] value_q, value_d;
    logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
    logic [4:0]                   count_q, count_d;

    logic              stat_we_q, stat_we_d;
    logic [4:0]        stat_index_q, stat_index_d;
    logic [5:0]        stat_data_q, stat_data_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_index_q, rf_index_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic             do_issue, issue_stat, do_commit, need_clear, cdb_hit;
    logic [4:0]       head_dest;
    logic [5:0]       head_tag, tail_tag, rd_eff;
    logic [PTR_W-1:0] cdb_idx;

    assign issue_ready = count_q < 5'(DEPTH);
    assign tail_tag    = 6'(tail_q);
    assign head_tag    = 6'(head_q);
    assign issue_tag   = tail_tag;
    assign head_dest   = dest_q[head_q];
    assign stat_rd_idx = head_dest;
    assign cdb_idx     = cdb_tag[PTR_W-1:0];

    always_comb begin
        do_issue   = issue_valid && issue_ready;
        issue_stat = do_issue && (issue_dest != 5'd0);
        // A status write still in flight to the head's register is not yet visible in the
        // table; look through it so a stalled commit sees a mapping the issue just replaced.
        rd_eff     = (stat_we_q && (stat_index_q == head_dest)) ? stat_data_q : stat_rd_q;
        need_clear = (head_dest != 5'd0) && (rd_eff == head_tag);
        do_commit  = busy_q[head_q] && ready_q[head_q] && !(need_clear && issue_stat);
        cdb_hit    = cdb_valid && (cdb_tag < 6'(DEPTH)) && busy_q[cdb_idx] && !ready_q[cdb_idx];
    end

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        dest_d  = dest_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + 5'(do_issue) - 5'(do_commit);

        if (cdb_hit) begin
            value_d[cdb_idx] = cdb_data;
            ready_d[cdb_idx] = 1'b1;
        end
        if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        // The tail slot is free whenever an issue is accepted, so it never aliases the head or CDB slot.
        if (do_issue) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            dest_d[tail_q]  = issue_dest;
            tail_d          = tail_q + PTR_W'(1);
        end
    end

    always_comb begin
        stat_we_d    = 1'b0;
        stat_index_d = stat_index_q;
        stat_data_d  = stat_data_q;
        rf_we_d      = 1'b0;
        rf_index_d   = rf_index_q;
        rf_data_d    = rf_data_q;

        if (issue_stat) begin
            stat_we_d    = 1'b1;
            stat_index_d = issue_dest;
            stat_data_d  = tail_tag;
        end else if (do_commit && need_clear) begin
            stat_we_d    = 1'b1;
            stat_index_d = head_dest;
            stat_data_d  = INVALID_TAG;
        end
        if (do_commit && (head_dest != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_index_d = head_dest;
            rf_data_d  = value_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            ready_q      <= '0;
            dest_q       <= '0;
            value_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            stat_we_q    <= 1'b0;
            stat_index_q <= '0;
            stat_data_q  <= INVALID_TAG;
            rf_we_q      <= 1'b0;
            rf_index_q   <= '0;
            rf_data_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            dest_q       <= dest_d;
            value_q      <= value_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            stat_we_q    <= stat_we_d;
            stat_index_q <= stat_index_d;
            stat_data_q  <= stat_data_d;
            rf_we_q      <= rf_we_d;
            rf_index_q   <= rf_index_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign stat_we    = stat_we_q;
    assign stat_index = stat_index_q;
    assign stat_data  = stat_data_q;
    assign rf_we      = rf_we_q;
    assign rf_index   = rf_index_q;
    assign rf_data    = rf_data_q;
    assign count      = count_q;

endmodule
